dbg_loader: RTL

DBG_LOADER -- requirements
Module: dbg_loader

---
 rtl/dbg_loader_if.sv | 21 ++
 rtl/dbg_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dbg_loader_if.sv
// Memory load bus plus the UART byte stream feeding dbg_loader.
// master = the loader side, slave = memory/receiver side.
interface dbg_loader_if;
    logic [31:0] addr;
    logic [31:0] din;
    logic        we_im;
    logic        we_dm;
    logic        clk_ld;
    logic [7:0]  rx_data;
    logic        rx_vld;

    modport master (
        output addr, din, we_im, we_dm, clk_ld,
        input  rx_data, rx_vld
    );

    modport slave (
        input  addr, din, we_im, we_dm, clk_ld,
        output rx_data, rx_vld
    );
endinterface

// File: rtl/dbg_loader.sv
// Debug loader: assembles UART bytes into 32-bit words and writes them to IM/DM
// with a separate load clock, framed by setup/hold windows.
module dbg_loader #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned HOLD_CYC    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        sel,
    input  logic [7:0]  base,
    input  logic [8:0]  count,
    input  logic        abort,
    dbg_loader_if.master bus,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  csum
);
    localparam int unsigned TmoW  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned HoldW = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [2:0] {
        StIdle, StRecv, StSetup, StStrobe, StHold, StNext, StFin
    } state_e;

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic [7:0]        addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic [31:0]       asm_q, asm_d;
    logic [1:0]        idx_q, idx_d;
    logic [8:0]        remain_q, remain_d;
    logic [7:0]        csum_q, csum_d;
    logic              err_q, err_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              abort_pend_q, abort_pend_d;
    logic              we_im_q, we_im_d, we_dm_q, we_dm_d;
    logic              clk_ld_q, clk_ld_d, busy_q, busy_d, done_q, done_d;
    logic              hold_last, wr_phase, pend;

    assign hold_last = (hold_q == HoldW'(HOLD_CYC - 1));

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        addr_d       = addr_q;
        din_d        = din_q;
        asm_d        = asm_q;
        idx_d        = idx_q;
        remain_d     = remain_q;
        csum_d       = csum_q;
        err_d        = err_q;
        hold_d       = hold_q;
        tmo_d        = '0;
        abort_pend_d = abort_pend_q;
        pend         = abort_pend_q | abort;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sel_d        = sel;
                    addr_d       = base;
                    remain_d     = count;
                    idx_d        = '0;
                    csum_d       = '0;
                    err_d        = 1'b0;
                    abort_pend_d = 1'b0;
                    state_d      = (count == 9'd0) ? StFin : StRecv;
                end
            end
            StRecv: begin
                tmo_d = tmo_q + TmoW'(1);
                // abort outranks a byte arriving in the same cycle
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (bus.rx_vld) begin
                    tmo_d  = '0;
                    csum_d = csum_q + bus.rx_data;
                    asm_d  = {bus.rx_data, asm_q[31:8]};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        din_d   = asm_d;
                        hold_d  = '0;
                        state_d = StSetup;
                    end
                end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StSetup: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (hold_last) begin
                    hold_d  = '0;
                    state_d = StStrobe;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StStrobe: begin
                // abort is remembered so the strobe and hold window always complete
                abort_pend_d = pend;
                hold_d       = '0;
                state_d      = StHold;
            end
            StHold: begin
                if (hold_last) begin
                    abort_pend_d = 1'b0;
                    hold_d       = '0;
                    if (pend) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StNext;
                    end
                end else begin
                    abort_pend_d = pend;
                    hold_d       = hold_q + HoldW'(1);
                end
            end
            StNext: begin
                remain_d = remain_q - 9'd1;
                addr_d   = addr_q + 8'd1;
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (remain_q == 9'd1) begin
                    state_d = StFin;
                end else begin
                    state_d = StRecv;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they register alongside it
        wr_phase = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);
        we_im_d  = wr_phase & ~sel_d;
        we_dm_d  = wr_phase & sel_d;
        clk_ld_d = (state_d == StStrobe);
        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StFin);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            sel_q        <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            asm_q        <= '0;
            idx_q        <= '0;
            remain_q     <= '0;
            csum_q       <= '0;
            err_q        <= 1'b0;
            hold_q       <= '0;
            tmo_q        <= '0;
            abort_pend_q <= 1'b0;
            we_im_q      <= 1'b0;
            we_dm_q      <= 1'b0;
            clk_ld_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            asm_q        <= asm_d;
            idx_q        <= idx_d;
            remain_q     <= remain_d;
            csum_q       <= csum_d;
            err_q        <= err_d;
            hold_q       <= hold_d;
            tmo_q        <= tmo_d;
            abort_pend_q <= abort_pend_d;
            we_im_q      <= we_im_d;
            we_dm_q      <= we_dm_d;
            clk_ld_q     <= clk_ld_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.addr   = {24'b0, addr_q};
    assign bus.din    = din_q;
    assign bus.we_im  = we_im_q;
    assign bus.we_dm  = we_dm_q;
    assign bus.clk_ld = clk_ld_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign csum       = csum_q;
endmodule
